// File: rtl/tl_tester_pkg.sv
// Shared TileLink-UL constants, adapter FSM states and beat-size helper
// for the tester client adapter.
package tl_tester_pkg;

    localparam logic [2:0] TL_GET      = 3'd4;
    localparam logic [2:0] TL_PUT_FULL = 3'd0;
    localparam logic [2:0] TL_ACK      = 3'd0;
    localparam logic [2:0] TL_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_SEND = 2'd1,
        D_WAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic int unsigned beat_bytes_log2(input int unsigned data_bits);
        return $clog2(data_bits / 8);
    endfunction

endpackage

// File: rtl/tl_tester_d_checker.sv
// Combinational validation of a D-channel beat against the outstanding
// transaction; selects the data returned to the request driver.
module tl_tester_d_checker
    import tl_tester_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned SOURCE_BITS = 4
) (
    input  logic                   is_write,
    input  logic [SOURCE_BITS-1:0] expected_source,
    input  logic [2:0]             d_opcode,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic                   d_denied,
    input  logic                   d_corrupt,
    input  logic [DATA_BITS-1:0]   d_data,
    output logic                   ok,
    output logic                   err,
    output logic [DATA_BITS-1:0]   resp_data
);

    logic [2:0] expected_opcode;

    always_comb begin
        expected_opcode = is_write ? TL_ACK : TL_ACK_DATA;
        err = (d_source != expected_source) || (d_opcode != expected_opcode)
              || d_denied || d_corrupt;
        ok = !err;
        if (err) begin
            resp_data = '1;
        end else if (is_write) begin
            resp_data = '0;
        end else begin
            resp_data = d_data;
        end
    end

endmodule

// File: rtl/tl_tester_client_adapter.sv
// Converts the tester driver's req/resp handshake into single-beat
// TileLink-UL Get/PutFullData transactions, one outstanding at a time.
module tl_tester_client_adapter
    import tl_tester_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 64,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned SOURCE_BITS    = 4,
    parameter int unsigned SIZE_BITS      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tlt_req_valid,
    output logic                   tlt_req_ready,
    input  logic [ADDR_BITS-1:0]   tlt_req_bits_addr,
    input  logic [DATA_BITS-1:0]   tlt_req_bits_data,
    input  logic                   tlt_req_bits_is_write,
    output logic                   tlt_resp_valid,
    output logic [DATA_BITS-1:0]   tlt_resp_bits_data,
    output logic                   a_valid,
    input  logic                   a_ready,
    output logic [2:0]             a_opcode,
    output logic [2:0]             a_param,
    output logic [SIZE_BITS-1:0]   a_size,
    output logic [SOURCE_BITS-1:0] a_source,
    output logic [ADDR_BITS-1:0]   a_address,
    output logic [DATA_BITS/8-1:0] a_mask,
    output logic [DATA_BITS-1:0]   a_data,
    output logic                   a_corrupt,
    input  logic                   d_valid,
    output logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [1:0]             d_param,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic                   d_sink,
    input  logic                   d_denied,
    input  logic                   d_corrupt,
    input  logic [DATA_BITS-1:0]   d_data,
    output logic [CNT_BITS-1:0]    err_count,
    output logic                   timeout_flag,
    output logic                   proto_err_flag
);

    localparam int unsigned LGB   = beat_bytes_log2(DATA_BITS);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_BITS-1:0] ALIGN_MASK = ADDR_BITS'((64'd1 << LGB) - 64'd1);
    localparam logic [CNT_W-1:0]     TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [DATA_BITS-1:0]   data_q;
    logic [2:0]             opcode_q;
    logic                   is_write_q;
    logic                   misaligned_q;
    logic [SOURCE_BITS-1:0] source_q;
    logic [CNT_W-1:0]       tmo_q;
    logic [DATA_BITS-1:0]   resp_data_q;
    logic [CNT_BITS-1:0]    err_q;
    logic                   timeout_q;
    logic                   proto_q;

    logic                   req_fire;
    logic                   misalign_now;
    logic                   d_accept;
    logic                   stray_beat;
    logic                   timeout_hit;
    logic                   err_event;
    logic                   chk_ok;
    logic                   chk_err;
    logic [DATA_BITS-1:0]   chk_data;
    logic                   unused_inputs;

    tl_tester_d_checker #(
        .DATA_BITS  (DATA_BITS),
        .SOURCE_BITS(SOURCE_BITS)
    ) u_d_checker (
        .is_write       (is_write_q),
        .expected_source(source_q),
        .d_opcode       (d_opcode),
        .d_source       (d_source),
        .d_denied       (d_denied),
        .d_corrupt      (d_corrupt),
        .d_data         (d_data),
        .ok             (chk_ok),
        .err            (chk_err),
        .resp_data      (chk_data)
    );

    assign unused_inputs = ^{d_param, d_size, d_sink, chk_ok};

    always_comb begin
        req_fire     = tlt_req_valid && (state_q == IDLE);
        misalign_now = req_fire && ((tlt_req_bits_addr & ALIGN_MASK) != '0);
        d_accept     = d_valid && (state_q == D_WAIT);
        stray_beat   = d_valid && (state_q != D_WAIT);
        timeout_hit  = (state_q == D_WAIT) && !d_valid && (tmo_q == TMO_LAST);
        err_event    = misalign_now || (d_accept && chk_err) || timeout_hit || stray_beat;
    end

    assign tlt_req_ready      = (state_q == IDLE);
    assign tlt_resp_valid     = (state_q == RESP);
    assign tlt_resp_bits_data = resp_data_q;
    // A misaligned request still passes through A_SEND, with a_valid held low.
    assign a_valid            = (state_q == A_SEND) && !misaligned_q;
    assign a_opcode           = opcode_q;
    assign a_param            = '0;
    assign a_size             = SIZE_BITS'(LGB);
    assign a_source           = source_q;
    assign a_address          = addr_q;
    assign a_mask             = '1;
    assign a_data             = data_q;
    assign a_corrupt          = 1'b0;
    assign d_ready            = 1'b1;
    assign err_count          = err_q;
    assign timeout_flag       = timeout_q;
    assign proto_err_flag     = proto_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            opcode_q     <= '0;
            is_write_q   <= 1'b0;
            misaligned_q <= 1'b0;
            source_q     <= '0;
            tmo_q        <= '0;
            resp_data_q  <= '0;
            err_q        <= '0;
            timeout_q    <= 1'b0;
            proto_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        addr_q       <= tlt_req_bits_addr;
                        data_q       <= tlt_req_bits_is_write ? tlt_req_bits_data : '0;
                        opcode_q     <= tlt_req_bits_is_write ? TL_PUT_FULL : TL_GET;
                        is_write_q   <= tlt_req_bits_is_write;
                        misaligned_q <= misalign_now;
                        state_q      <= A_SEND;
                    end
                end
                A_SEND: begin
                    if (misaligned_q) begin
                        resp_data_q <= '1;
                        state_q     <= RESP;
                    end else if (a_ready) begin
                        tmo_q   <= '0;
                        state_q <= D_WAIT;
                    end
                end
                D_WAIT: begin
                    if (d_valid) begin
                        resp_data_q <= chk_data;
                        state_q     <= RESP;
                    end else if (tmo_q == TMO_LAST) begin
                        resp_data_q <= '1;
                        state_q     <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                RESP: begin
                    source_q <= source_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (stray_beat || (d_accept && chk_err)) begin
                proto_q <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (err_event && (err_q != '1)) begin
                err_q <= err_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tl_tester_client_adapter.sv
// Directed self-checking bench for tl_tester_client_adapter (TIMEOUT_CYCLES=8).
module tb_tl_tester_client_adapter;

    logic        clock = 1'b0;
    logic        reset;
    logic        tlt_req_valid;
    logic        tlt_req_ready;
    logic [63:0] tlt_req_bits_addr;
    logic [31:0] tlt_req_bits_data;
    logic        tlt_req_bits_is_write;
    logic        tlt_resp_valid;
    logic [31:0] tlt_resp_bits_data;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [3:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic        d_corrupt;
    logic [31:0] d_data;
    logic [15:0] err_count;
    logic        timeout_flag;
    logic        proto_err_flag;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [3:0]  exp_src  = 4'd0;

    always #5 clock = ~clock;

    tl_tester_client_adapter #(
        .ADDR_BITS     (64),
        .DATA_BITS     (32),
        .SOURCE_BITS   (4),
        .SIZE_BITS     (3),
        .TIMEOUT_CYCLES(8),
        .CNT_BITS      (16)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .tlt_req_valid        (tlt_req_valid),
        .tlt_req_ready        (tlt_req_ready),
        .tlt_req_bits_addr    (tlt_req_bits_addr),
        .tlt_req_bits_data    (tlt_req_bits_data),
        .tlt_req_bits_is_write(tlt_req_bits_is_write),
        .tlt_resp_valid       (tlt_resp_valid),
        .tlt_resp_bits_data   (tlt_resp_bits_data),
        .a_valid              (a_valid),
        .a_ready              (a_ready),
        .a_opcode             (a_opcode),
        .a_param              (a_param),
        .a_size               (a_size),
        .a_source             (a_source),
        .a_address            (a_address),
        .a_mask               (a_mask),
        .a_data               (a_data),
        .a_corrupt            (a_corrupt),
        .d_valid              (d_valid),
        .d_ready              (d_ready),
        .d_opcode             (d_opcode),
        .d_param              (d_param),
        .d_size               (d_size),
        .d_source             (d_source),
        .d_sink               (d_sink),
        .d_denied             (d_denied),
        .d_corrupt            (d_corrupt),
        .d_data               (d_data),
        .err_count            (err_count),
        .timeout_flag         (timeout_flag),
        .proto_err_flag       (proto_err_flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_src = 4'd0;
    endtask

    task automatic xact(input string tag, input logic [63:0] addr, input logic [31:0] wdata,
                        input logic wr, input int a_stall, input int d_delay,
                        input logic [2:0] dop, input logic [3:0] dsrc, input logic dden,
                        input logic [31:0] ddata, input logic [31:0] exp_resp);
        logic [31:0] exp_adata;
        logic [2:0]  exp_op;
        exp_adata = wr ? wdata : 32'd0;
        exp_op    = wr ? 3'd0 : 3'd4;
        tlt_req_valid = 1'b1;
        tlt_req_bits_addr = addr;
        tlt_req_bits_data = wdata;
        tlt_req_bits_is_write = wr;
        @(negedge clock);
        check({tag, ".req_ready"}, tlt_req_ready, 1);
        check({tag, ".a_valid_idle"}, a_valid, 0);
        step();
        tlt_req_valid = 1'b0;
        tlt_req_bits_data = 32'h5A5A5A5A;
        for (int i = 0; i < a_stall; i++) begin
            @(negedge clock);
            check({tag, ".stall_a_valid"}, a_valid, 1);
            check({tag, ".stall_addr"}, a_address, addr);
            check({tag, ".stall_data"}, a_data, exp_adata);
            check({tag, ".stall_opcode"}, a_opcode, exp_op);
            check({tag, ".stall_ready"}, tlt_req_ready, 0);
            step();
        end
        a_ready = 1'b1;
        @(negedge clock);
        check({tag, ".a_valid"}, a_valid, 1);
        check({tag, ".a_opcode"}, a_opcode, exp_op);
        check({tag, ".a_source"}, a_source, exp_src);
        check({tag, ".a_address"}, a_address, addr);
        check({tag, ".a_data"}, a_data, exp_adata);
        check({tag, ".a_mask"}, a_mask, 4'hF);
        check({tag, ".a_size"}, a_size, 3'd2);
        check({tag, ".a_param_corrupt"}, {a_param, a_corrupt}, 0);
        step();
        a_ready = 1'b0;
        for (int i = 0; i < d_delay; i++) begin
            @(negedge clock);
            check({tag, ".dwait_resp"}, tlt_resp_valid, 0);
            step();
        end
        d_valid = 1'b1;
        d_opcode = dop;
        d_source = dsrc;
        d_denied = dden;
        d_data = ddata;
        @(negedge clock);
        check({tag, ".resp_early"}, tlt_resp_valid, 0);
        check({tag, ".d_ready"}, d_ready, 1);
        step();
        d_valid = 1'b0;
        d_denied = 1'b0;
        @(negedge clock);
        check({tag, ".resp_valid"}, tlt_resp_valid, 1);
        check({tag, ".resp_data"}, tlt_resp_bits_data, exp_resp);
        check({tag, ".ready_in_resp"}, tlt_req_ready, 0);
        step();
        @(negedge clock);
        check({tag, ".resp_one_cycle"}, tlt_resp_valid, 0);
        exp_src = exp_src + 4'd1;
        step();
    endtask

    initial begin
        int cyc;
        tlt_req_valid = 0; tlt_req_bits_addr = 0; tlt_req_bits_data = 0; tlt_req_bits_is_write = 0;
        a_ready = 0; d_valid = 0; d_opcode = 0; d_param = 0; d_size = 0; d_source = 0;
        d_sink = 0; d_denied = 0; d_corrupt = 0; d_data = 0;
        #1;
        do_reset();
        @(negedge clock);
        check("rst.a_valid", a_valid, 0);
        check("rst.resp_valid", tlt_resp_valid, 0);
        check("rst.resp_data", tlt_resp_bits_data, 0);
        check("rst.err_count", err_count, 0);
        check("rst.flags", {timeout_flag, proto_err_flag}, 0);
        check("rst.a_source", a_source, 0);
        check("rst.a_payload", {a_address, a_data, a_opcode}, 0);
        check("rst.req_ready", tlt_req_ready, 1);
        step();

        xact("read0", 64'h1000, 32'h0, 1'b0, 0, 0, 3'd1, exp_src, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D);
        check("read0.err", err_count, 0);
        xact("write_bp", 64'h2004, 32'h12345678, 1'b1, 5, 0, 3'd0, exp_src, 1'b0, 32'hDEADBEEF, 32'h0);
        check("write_bp.err", err_count, 0);

        for (int i = 0; i < 17; i++) begin
            logic [31:0] v;
            v = 32'h01010101 * (i + 1);
            xact("wrap", 64'h3000 + 64'(i * 4), 32'h0, 1'b0, 0, i % 3, 3'd1, exp_src, 1'b0, v, v);
        end
        check("wrap.src_after", a_source, 4'd3);
        check("wrap.err", {err_count, proto_err_flag}, 0);

        tlt_req_valid = 1'b1;
        tlt_req_bits_addr = 64'h1002;
        tlt_req_bits_is_write = 1'b0;
        @(negedge clock);
        check("mis.req_ready", tlt_req_ready, 1);
        step();
        tlt_req_valid = 1'b0;
        a_ready = 1'b1;
        @(negedge clock);
        check("mis.no_a_valid", a_valid, 0);
        check("mis.resp_n1", tlt_resp_valid, 0);
        step();
        @(negedge clock);
        check("mis.no_a_valid2", a_valid, 0);
        check("mis.resp_valid", tlt_resp_valid, 1);
        check("mis.resp_data", tlt_resp_bits_data, 32'hFFFFFFFF);
        check("mis.err", err_count, 1);
        check("mis.proto_flag", proto_err_flag, 0);
        step();
        a_ready = 1'b0;
        exp_src = exp_src + 4'd1;

        do_reset();
        tlt_req_valid = 1'b1;
        tlt_req_bits_addr = 64'h4000;
        tlt_req_bits_is_write = 1'b0;
        step();
        tlt_req_valid = 1'b0;
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        cyc = 0;
        @(negedge clock);
        while (!tlt_resp_valid && cyc < 20) begin
            step();
            cyc++;
            @(negedge clock);
        end
        check("tmo.latency", cyc, 8);
        check("tmo.resp_data", tlt_resp_bits_data, 32'hFFFFFFFF);
        check("tmo.flag", timeout_flag, 1);
        check("tmo.err", err_count, 1);
        check("tmo.proto_flag", proto_err_flag, 0);
        step();
        exp_src = exp_src + 4'd1;
        d_valid = 1'b1;
        d_opcode = 3'd1;
        d_source = 4'd0;
        step();
        d_valid = 1'b0;
        @(negedge clock);
        check("stray.proto_flag", proto_err_flag, 1);
        check("stray.err", err_count, 2);
        check("stray.state_idle", tlt_req_ready, 1);
        step();

        xact("denied", 64'h5000, 32'h0, 1'b0, 0, 1, 3'd1, exp_src, 1'b1, 32'h11111111, 32'hFFFFFFFF);
        check("denied.err", err_count, 3);
        xact("badsrc", 64'h5004, 32'h0, 1'b0, 0, 0, 3'd1, exp_src + 4'd1, 1'b0, 32'h22222222, 32'hFFFFFFFF);
        check("badsrc.err", err_count, 4);
        xact("badop", 64'h5008, 32'h99, 1'b1, 0, 0, 3'd1, exp_src, 1'b0, 32'h0, 32'hFFFFFFFF);
        check("badop.err", err_count, 5);

        tlt_req_valid = 1'b1;
        tlt_req_bits_addr = 64'h6000;
        step();
        tlt_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("midrst.a_valid_before", a_valid, 1);
        step();
        reset = 1'b0;
        exp_src = 4'd0;
        @(negedge clock);
        check("midrst.a_valid", a_valid, 0);
        check("midrst.resp_valid", tlt_resp_valid, 0);
        check("midrst.err", err_count, 0);
        check("midrst.flags", {timeout_flag, proto_err_flag}, 0);
        check("midrst.a_source", a_source, 0);
        step();

        xact("dwins", 64'h7000, 32'h0, 1'b0, 0, 7, 3'd1, exp_src, 1'b0, 32'hA5A5F00D, 32'hA5A5F00D);
        check("dwins.timeout_flag", timeout_flag, 0);
        check("dwins.err", err_count, 0);
        xact("write_ok", 64'h7008, 32'hFEEDFACE, 1'b1, 0, 0, 3'd0, exp_src, 1'b0, 32'h0, 32'h0);
        check("write_ok.src", a_source, 4'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
